// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_pkg
// Description : Shared async-FIFO constants and Gray/binary conversion helpers
// Revision    : 1.0
// ============================================================================
package fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int GRAY_MAX_W         = 32;

    // Both helpers are width-agnostic: zero-extend a narrower code on the way
    // in and keep the low bits of the result.
    function automatic logic [GRAY_MAX_W-1:0] bin_to_gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wptr_full_if.sv
`default_nettype none
// ============================================================================
// Interface   : fifo_wptr_full_if
// Description : Producer, memory-write and synchronizer signals of the write side
// Revision    : 1.0
// ============================================================================
interface fifo_wptr_full_if
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  w_en;
    logic                  ovf_clr;
    logic [ADDR_WIDTH:0]   rptr_sync;
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  w_accept;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;

    modport master (
        output w_en, ovf_clr, rptr_sync,
        input  wptr, waddr, w_accept, full, almost_full, level, overflow
    );

    modport slave (
        input  w_en, ovf_clr, rptr_sync,
        output wptr, waddr, w_accept, full, almost_full, level, overflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wptr_full_gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin
// Description : Combinational Gray-to-binary converter (XOR prefix from MSB)
// Revision    : 1.0
// ============================================================================
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  wire logic [WIDTH-1:0] gray,
    output logic      [WIDTH-1:0] bin
);
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign bin[i] = ^gray[WIDTH-1:i];
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wptr_full
// Description : Async FIFO write-side pointer, full/almost-full, level, overflow
// Revision    : 1.0
// ============================================================================
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AF_THRESH  = 12
) (
    input  wire logic clk,
    input  wire logic rst,
    fifo_wptr_full_if.slave bus
);
    localparam int             PW       = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]  AF_LEVEL = PW'(AF_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] full_match;
    logic          accept;

    gray2bin #(
        .WIDTH (PW)
    ) u_rptr_g2b (
        .gray (bus.rptr_sync),
        .bin  (rbin)
    );

    assign accept       = bus.w_en & ~bus.full;
    assign bus.w_accept = accept;

    assign wbin_next  = wbin + PW'(accept);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign level_next = wbin_next - rbin;

    // Full means the write pointer is exactly one lap ahead: in Gray code that
    // is the read pointer with its two MSBs inverted.
    assign full_match = {~bus.rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                          bus.rptr_sync[ADDR_WIDTH-2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin            <= '0;
            bus.wptr        <= '0;
            bus.waddr       <= '0;
            bus.full        <= 1'b0;
            bus.almost_full <= 1'b0;
            bus.level       <= '0;
        end else begin
            wbin            <= wbin_next;
            bus.wptr        <= wgray_next;
            bus.waddr       <= wbin_next[ADDR_WIDTH-1:0];
            bus.full        <= (wgray_next == full_match);
            bus.almost_full <= (level_next >= AF_LEVEL);
            bus.level       <= level_next;
        end
    end

    // A rejected write outranks a same-cycle clear so no overflow is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.overflow <= 1'b0;
        end else if (bus.w_en && bus.full) begin
            bus.overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            bus.overflow <= 1'b0;
        end
    end

    a_wptr_one_bit : assert property (@(posedge clk) disable iff (!rst)
        $countones(bus.wptr ^ $past(bus.wptr)) <= 1);

    a_full_level : assert property (@(posedge clk) disable iff (!rst)
        bus.full |-> (bus.level == PW'(1 << ADDR_WIDTH)));

endmodule
`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wptr_full
// Description : Scoreboard testbench for the FIFO write-side pointer block
// Revision    : 1.0
// ============================================================================
module tb_fifo_wptr_full;
    localparam int AW    = 4;
    localparam int AF    = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_wptr_full #(
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] wptr;
        logic [3:0] waddr;
        logic       full;
        logic       af;
        logic [4:0] level;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    logic [4:0] m_wbin;
    logic       m_full;
    logic       m_ovf;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wbin = '0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Drive one cycle of stimulus, predict the post-edge state, queue it.
    task automatic step(input logic we, input logic clr, input logic [4:0] rb);
        exp_t       e;
        logic       acc;
        logic [4:0] nb;
        logic [4:0] lvl;
        bus.w_en      = we;
        bus.ovf_clr   = clr;
        bus.rptr_sync = to_gray(rb);
        acc = we && !m_full;
        nb  = m_wbin + {4'd0, acc};
        lvl = nb - rb;
        if (we && m_full) m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
        m_full  = (lvl == 5'd16);
        m_wbin  = nb;
        e.wptr  = to_gray(nb);
        e.waddr = nb[3:0];
        e.full  = m_full;
        e.af    = (int'(lvl) >= AF);
        e.level = lvl;
        e.ovf   = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.wptr !== e.wptr) begin
                errors++;
                $display("FAIL sb_wptr got %b want %b", bus.wptr, e.wptr);
            end
            checks++;
            if (bus.waddr !== e.waddr) begin
                errors++;
                $display("FAIL sb_waddr got %0d want %0d", bus.waddr, e.waddr);
            end
            checks++;
            if (bus.full !== e.full) begin
                errors++;
                $display("FAIL sb_full got %b want %b", bus.full, e.full);
            end
            checks++;
            if (bus.almost_full !== e.af) begin
                errors++;
                $display("FAIL sb_almost_full got %b want %b", bus.almost_full, e.af);
            end
            checks++;
            if (bus.level !== e.level) begin
                errors++;
                $display("FAIL sb_level got %0d want %0d", bus.level, e.level);
            end
            checks++;
            if (bus.overflow !== e.ovf) begin
                errors++;
                $display("FAIL sb_overflow got %b want %b", bus.overflow, e.ovf);
            end
        end
    end

    task automatic do_reset();
        bus.w_en      = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.rptr_sync = '0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0);
        #1;
        bus.w_en = 1'b1;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.wptr, bus.waddr, bus.full, bus.almost_full, bus.level, bus.overflow} !== '0) begin
            errors++;
            $display("FAIL reset_async wptr=%b waddr=%0d full=%b af=%b level=%0d ovf=%b want all 0",
                     bus.wptr, bus.waddr, bus.full, bus.almost_full, bus.level, bus.overflow);
        end
        bus.w_en = 1'b0;
        model_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        step(1'b1, 1'b0, 5'd0);
        checks++;
        if (bus.waddr !== 4'd1 || bus.wptr !== 5'b00001) begin
            errors++;
            $display("FAIL reset_first_write waddr=%0d wptr=%b want 1 00001", bus.waddr, bus.wptr);
        end
    endtask

    task automatic test_fill();
        do_reset();
        bus.w_en = 1'b1;
        #1;
        checks++;
        if (bus.w_accept !== 1'b1) begin
            errors++;
            $display("FAIL fill_accept got %b want 1", bus.w_accept);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 5'd0);
            if (i == 10) begin
                checks++;
                if (bus.almost_full !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_af_11 got %b want 0", bus.almost_full);
                end
            end
            if (i == 11) begin
                checks++;
                if (bus.almost_full !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_af_12 got %b want 1", bus.almost_full);
                end
            end
        end
        checks++;
        if (bus.full !== 1'b1 || bus.level !== 5'd16 || bus.waddr !== 4'd0 || bus.wptr !== 5'b11000) begin
            errors++;
            $display("FAIL fill_end full=%b level=%0d waddr=%0d wptr=%b want 1 16 0 11000",
                     bus.full, bus.level, bus.waddr, bus.wptr);
        end
    endtask

    task automatic test_overflow();
        bus.w_en = 1'b1;
        #1;
        checks++;
        if (bus.w_accept !== 1'b0) begin
            errors++;
            $display("FAIL ovf_accept got %b want 0", bus.w_accept);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0);
        checks++;
        if (bus.wptr !== 5'b11000 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set wptr=%b ovf=%b want 11000 1", bus.wptr, bus.overflow);
        end
        step(1'b1, 1'b1, 5'd0);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins got %b want 1", bus.overflow);
        end
        step(1'b0, 1'b1, 5'd0);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", bus.overflow);
        end
    endtask

    task automatic test_drain();
        step(1'b0, 1'b0, 5'd1);
        checks++;
        if (bus.full !== 1'b0 || bus.level !== 5'd15) begin
            errors++;
            $display("FAIL drain_release full=%b level=%0d want 0 15", bus.full, bus.level);
        end
        step(1'b1, 1'b0, 5'd1);
        checks++;
        if (bus.full !== 1'b1 || bus.level !== 5'd16) begin
            errors++;
            $display("FAIL drain_refill full=%b level=%0d want 1 16", bus.full, bus.level);
        end
    endtask

    task automatic test_simultaneous();
        step(1'b0, 1'b0, 5'd2);
        step(1'b1, 1'b0, 5'd2);
        step(1'b1, 1'b0, 5'd3);
        checks++;
        if (bus.level !== 5'd15 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous level=%0d full=%b want 15 0", bus.level, bus.full);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] rb;
        logic [4:0] prev;
        do_reset();
        rb   = '0;
        prev = '0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, rb);
            checks++;
            if ($countones(prev ^ bus.wptr) != 1) begin
                errors++;
                $display("FAIL wrap_gray_step write %0d prev=%b now=%b", i, prev, bus.wptr);
            end
            prev = bus.wptr;
            rb   = rb + 5'd1;
            step(1'b0, 1'b0, rb);
            checks++;
            if (bus.full !== 1'b0 || bus.level > 5'd1) begin
                errors++;
                $display("FAIL wrap_status write %0d full=%b level=%0d want 0 <=1", i, bus.full, bus.level);
            end
        end
        checks++;
        if (bus.waddr !== 4'd8 || bus.wptr !== to_gray(5'd8)) begin
            errors++;
            $display("FAIL wrap_end waddr=%0d wptr=%b want 8 %b", bus.waddr, bus.wptr, to_gray(5'd8));
        end
    endtask

    initial begin
        bus.w_en      = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.rptr_sync = '0;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_simultaneous();
        test_wrap();
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain pending %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached without completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
